// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequences jumps, taken branches, stalls and jr operand waits,
// and issues the IF/ID and ID/EX squash pulses that accompany each redirect.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        j_req,
  input  logic        jr,
  input  logic        jr_ready,
  input  logic [31:0] j_addr,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        wait_pending,
  output logic        wait_err,
  output logic        misalign
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {RUN, JR_WAIT} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   pc_plus4_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          if_id_reg, if_id_next;
  logic          id_ex_reg, id_ex_next;
  logic          err_reg, err_next;
  logic          mis_reg, mis_next;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    if_id_next = 1'b0;
    id_ex_next = 1'b0;
    err_next   = err_reg;
    mis_next   = mis_reg;

    // A taken branch outranks everything: the ID instruction is wrong-path.
    if (br_taken) begin
      pc_next    = {br_addr[31:2], 2'b00};
      mis_next   = mis_reg | (|br_addr[1:0]);
      if_id_next = 1'b1;
      id_ex_next = 1'b1;
      state_next = RUN;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (stall) begin
            pc_next = pc_reg;
          end else if (j_req && jr && !jr_ready) begin
            state_next = JR_WAIT;
            cnt_next   = CNT_ONE;
            id_ex_next = 1'b1;
            if (CNT_ONE == CNT_MAX) err_next = 1'b1;
          end else if (j_req) begin
            pc_next    = {j_addr[31:2], 2'b00};
            mis_next   = mis_reg | (|j_addr[1:0]);
            if_id_next = 1'b1;
          end else begin
            pc_next = pc_reg + 32'd4;
          end
        end
        JR_WAIT: begin
          if (jr_ready && !stall) begin
            pc_next    = {j_addr[31:2], 2'b00};
            mis_next   = mis_reg | (|j_addr[1:0]);
            if_id_next = 1'b1;
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            // Keep bubbling ID/EX; the wait counter saturates at MAX_WAIT.
            id_ex_next = 1'b1;
            if (cnt_reg < CNT_MAX) cnt_next = cnt_reg + CNT_ONE;
            if (cnt_next == CNT_MAX) err_next = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      pc_plus4_reg <= RESET_PC + 32'd4;
      cnt_reg      <= '0;
      if_id_reg    <= 1'b0;
      id_ex_reg    <= 1'b0;
      err_reg      <= 1'b0;
      mis_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pc_plus4_reg <= pc_next + 32'd4;
      cnt_reg      <= cnt_next;
      if_id_reg    <= if_id_next;
      id_ex_reg    <= id_ex_next;
      err_reg      <= err_next;
      mis_reg      <= mis_next;
    end
  end

  assign pc           = pc_reg;
  assign pc_plus4     = pc_plus4_reg;
  assign if_id_flush  = if_id_reg;
  assign id_ex_flush  = id_ex_reg;
  assign wait_pending = (state_reg == JR_WAIT);
  assign wait_err     = err_reg;
  assign misalign     = mis_reg;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vector table, hand-written corner
// sequences, then random stimulus against a behavioural model.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst, stall, j_req, jr, jr_ready, br_taken;
  logic [31:0] j_addr, br_addr;
  logic [31:0] pc, pc_plus4;
  logic        if_id_flush, id_ex_flush, wait_pending, wait_err, misalign;

  int checks   = 0;
  int failures = 0;

  pc_redirect_ctrl #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .j_req(j_req), .jr(jr),
    .jr_ready(jr_ready), .j_addr(j_addr), .br_taken(br_taken), .br_addr(br_addr),
    .pc(pc), .pc_plus4(pc_plus4), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .wait_pending(wait_pending),
    .wait_err(wait_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, j_req, jr, jr_ready, br_taken;
    logic [31:0] j_addr, br_addr, exp_pc;
    logic [4:0]  exp_flags;  // {if_id, id_ex, wait_pending, wait_err, misalign}
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic jq, logic j, logic jrdy,
                              logic [31:0] ja, logic bt, logic [31:0] ba,
                              logic [31:0] epc, logic [4:0] ef);
    vec_t v;
    v.rst = r; v.stall = s; v.j_req = jq; v.jr = j; v.jr_ready = jrdy;
    v.j_addr = ja; v.br_taken = bt; v.br_addr = ba;
    v.exp_pc = epc; v.exp_flags = ef;
    return v;
  endfunction

  function automatic vec_t idle(logic [31:0] epc, logic [4:0] ef);
    return mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, epc, ef);
  endfunction

  // Behavioural model: "waiting" plus a count of wait cycles spent so far.
  logic [31:0] m_pc;
  bit          m_waiting, m_ifid, m_idex, m_err, m_mis;
  int          m_waited;

  function automatic logic [4:0] dut_flags();
    return {if_id_flush, id_ex_flush, wait_pending, wait_err, misalign};
  endfunction

  task automatic model_take(input logic [31:0] a);
    m_pc = a & 32'hFFFF_FFFC;
    if (a % 4 != 0) m_mis = 1;
    m_ifid = 1;
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = RESET_PC; m_waiting = 0; m_waited = 0;
      m_ifid = 0; m_idex = 0; m_err = 0; m_mis = 0;
    end else begin
      m_ifid = 0; m_idex = 0;
      if (br_taken) begin
        model_take(br_addr); m_idex = 1; m_waiting = 0; m_waited = 0;
      end else if (m_waiting) begin
        if (jr_ready && !stall) begin
          model_take(j_addr); m_waiting = 0; m_waited = 0;
        end else begin
          m_idex = 1;
          m_waited = (m_waited + 1 > MAX_WAIT) ? MAX_WAIT : m_waited + 1;
          if (m_waited == MAX_WAIT) m_err = 1;
        end
      end else if (stall) begin
        // pc holds
      end else if (j_req && jr && !jr_ready) begin
        m_waiting = 1; m_waited = 1; m_idex = 1;
        if (MAX_WAIT == 1) m_err = 1;
      end else if (j_req) begin
        model_take(j_addr);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; j_req = v.j_req; jr = v.jr; jr_ready = v.jr_ready;
    j_addr = v.j_addr; br_taken = v.br_taken; br_addr = v.br_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    tick();
    $display("%s pc=%h pc_plus4=%h flags=%b", tag, pc, pc_plus4, dut_flags());
    check({tag, ".pc"}, pc, v.exp_pc);
    check({tag, ".pc_plus4"}, pc_plus4, v.exp_pc + 32'd4);
    check({tag, ".flags"}, {27'd0, dut_flags()}, {27'd0, v.exp_flags});
  endtask

  vec_t tbl[25];

  initial begin
    drive(idle(0, 0));
    rst = 1'b1;

    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'b00000);
    tbl[1]  = idle(32'h04, 5'b00000);
    tbl[2]  = idle(32'h08, 5'b00000);
    tbl[3]  = idle(32'h0C, 5'b00000);
    tbl[4]  = idle(32'h10, 5'b00000);
    tbl[5]  = mk(0, 0, 1, 0, 0, 32'h400, 0, 32'h0, 32'h400, 5'b10000);
    tbl[6]  = idle(32'h404, 5'b00000);
    tbl[7]  = mk(0, 0, 1, 0, 0, 32'h20, 0, 32'h0, 32'h20, 5'b10000);
    tbl[8]  = mk(0, 0, 1, 1, 0, 32'h80, 0, 32'h0, 32'h20, 5'b01100);
    tbl[9]  = mk(0, 0, 1, 1, 0, 32'h80, 0, 32'h0, 32'h20, 5'b01100);
    tbl[10] = mk(0, 0, 1, 1, 1, 32'h80, 0, 32'h0, 32'h80, 5'b10000);
    tbl[11] = idle(32'h84, 5'b00000);
    tbl[12] = mk(0, 0, 1, 0, 0, 32'h300, 1, 32'h200, 32'h200, 5'b11000);
    tbl[13] = idle(32'h204, 5'b00000);
    tbl[14] = mk(0, 0, 1, 1, 0, 32'h300, 0, 32'h0, 32'h204, 5'b01100);
    tbl[15] = mk(0, 0, 1, 1, 0, 32'h300, 1, 32'h200, 32'h200, 5'b11000);
    tbl[16] = idle(32'h204, 5'b00000);
    tbl[17] = mk(0, 0, 1, 0, 0, 32'h40, 0, 32'h0, 32'h40, 5'b10000);
    tbl[18] = mk(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h40, 5'b00000);
    tbl[19] = mk(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h40, 5'b00000);
    tbl[20] = mk(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h40, 5'b00000);
    tbl[21] = idle(32'h44, 5'b00000);
    tbl[22] = mk(0, 0, 1, 0, 0, 32'h103, 0, 32'h0, 32'h100, 5'b10001);
    tbl[23] = idle(32'h104, 5'b00001);
    tbl[24] = mk(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'b00000);

    for (int i = 0; i < 25; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Long jr wait: wait_err appears on the 4th wait cycle and stays sticky.
    for (int k = 1; k <= 6; k++)
      run_vec(mk(0, 0, 1, 1, 0, 32'h500, 0, 32'h0, 32'h0, {3'b011, (k >= MAX_WAIT), 1'b0}),
              $sformatf("errwait%0d", k));
    run_vec(mk(0, 0, 1, 1, 1, 32'h500, 0, 32'h0, 32'h500, 5'b10010), "errjump");
    run_vec(idle(32'h504, 5'b00010), "errafter");

    // Stall concurrent with jr_ready in JR_WAIT defers the jump.
    run_vec(mk(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'b00000), "stwrst");
    run_vec(mk(0, 0, 1, 1, 0, 32'h600, 0, 32'h0, 32'h0, 5'b01100), "stwenter");
    for (int k = 0; k < 2; k++) begin
      drive(mk(0, 1, 1, 1, 1, 32'h600, 0, 32'h0, 32'h0, 5'b0));
      tick();
      $display("stwstall%0d pc=%h wait_pending=%b if_id=%b", k, pc, wait_pending, if_id_flush);
      check("stwstall.pc", pc, 32'h0);
      check("stwstall.wait_pending", {31'd0, wait_pending}, 32'd1);
      check("stwstall.if_id", {31'd0, if_id_flush}, 32'd0);
    end
    run_vec(mk(0, 0, 1, 1, 1, 32'h600, 0, 32'h0, 32'h600, 5'b10000), "stwjump");

    // Sequential wrap past the top of the address space.
    run_vec(mk(0, 0, 1, 0, 0, 32'hFFFF_FFF8, 0, 32'h0, 32'hFFFF_FFF8, 5'b10000), "wrapj");
    run_vec(idle(32'hFFFF_FFFC, 5'b00000), "wrap1");
    run_vec(idle(32'h0000_0000, 5'b00000), "wrap2");

    // Reset in the middle of a jr wait: no flush, all flags clear.
    run_vec(mk(0, 0, 1, 1, 0, 32'h700, 0, 32'h0, 32'h0, 5'b01100), "rstwenter");
    run_vec(mk(1, 0, 1, 1, 1, 32'h700, 0, 32'h0, RESET_PC, 5'b00000), "rstwrst");
    run_vec(idle(RESET_PC + 32'd4, 5'b00000), "rstwafter");

    // Random stimulus against the model.
    drive(mk(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'b0));
    tick();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(99) == 0);
      stall    = ($urandom_range(99) < 15);
      j_req    = ($urandom_range(99) < 30);
      jr       = $urandom_range(1);
      jr_ready = ($urandom_range(99) < 35);
      br_taken = ($urandom_range(99) < 10);
      j_addr   = ($urandom_range(3) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
      br_addr  = ($urandom_range(3) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
      tick();
      $display("rnd%0d pc=%h flags=%b model_pc=%h", i, pc, dut_flags(), m_pc);
      check("rnd.pc", pc, m_pc);
      check("rnd.pc_plus4", pc_plus4, m_pc + 32'd4);
      check("rnd.flags", {27'd0, dut_flags()},
            {27'd0, m_ifid, m_idex, m_waiting, m_err, m_mis});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
